fsmd_sched: RTL and testbench
=============================

# fsmd_sched

Two-requester scheduler and sequencer for the shared add/multiply FSMD datapath. It accepts jobs of five W-bit operands (a, b, c, d, e) from two requesters and arbitrates between them round-robin. For the granted job it runs one shared adder and one shared multiplier through a fixed six-step sequence to produce y1 = (a+b+c)·e and y2 = (a+b+c)·(c+d), then returns both results to the owning requester with a done pulse. It sits between the requesting control blocks and the arithmetic datapath registers R1/R2/R3.

## Interface
- W, 4: operand width; result width RW = 2·W+3 (exact, no overflow).
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- req  in  2  request level per requester, bit i = requester i.
- op_a, op_b, op_c, op_d, op_e  in  2·W each  operands; requester i at [i·W +: W].
- grant  out  2  one-hot, one-cycle pulse: job of requester i accepted.
- done  out  2  one-hot, one-cycle pulse: results valid for requester i.
- y1  out  RW  (a+b+c)·e of the last completed job.
- y2  out  RW  (a+b+c)·(c+d) of the last completed job.
- busy  out  1  high whenever state ≠ IDLE.
- state  out  3  current state encoding, for debug.

## Operation
- States and encoding: IDLE=0, S1=1, S2=2, S3=3, S4=4, S5=5, DONE=6. Encoding 7 is illegal and returns to IDLE.
- Internal registers: R1, R2, R3 (RW bits each), owner (1 bit), last (round-robin pointer), and held copies of b, d, e.
- IDLE with req≠0 (acceptance):
  - Pick the winner: if only one requester is active it wins; if both are active, the requester ≠ last wins.
  - Capture R1←a, R2←c and b, d, e of the winner; set owner←winner and last←winner; go to S1.
- S1: R1←R1+R2; R3←d; grant[owner]=1 during this cycle.
- S2: R2←R2+R3; R3←b.
- S3: R1←R1+R3 (adder only).
- S4: R2←R1·R2; R3←e (multiplier only).
- S5: R1←R1·R3; y1←R1·R3; y2←R2.
- DONE: done[owner]=1; go to IDLE.
- Resource sharing: at most one addition per cycle (S1–S3) and at most one multiplication per cycle (S4–S5).
- Widths: all arithmetic is zero-extended to RW bits. The maximum result, 6·(2^W−1)², fits RW bits.
- Requester rule:
  - Hold req and operands stable until grant is seen, then drop req.
  - Operands are only sampled at the acceptance edge; changes after acceptance have no effect.
  - A req still high when the scheduler returns to IDLE counts as a new job.
- req changes outside IDLE are ignored; no queueing.
- y1/y2 hold their value until the next S5 update.

## Timing
- Reset values: state=IDLE, grant=0, done=0, y1=0, y2=0, busy=0, R1–R3=0, owner=0, last=1 (so requester 0 wins the first tie).
- Reset mid-job: the job is dropped, with no done and no grant pulse; busy falls immediately (asynchronous).
- Per-job cycle sequence:
  - Acceptance edge E0 → S1 (grant high).
  - E1 → S2, E2 → S3, E3 → S4, E4 → S5.
  - E5 → DONE (y1/y2 valid, done high).
  - E6 → IDLE.
- Latency: grant 1 cycle after acceptance; done 6 cycles after acceptance.
- Throughput: the next acceptance is no earlier than edge E7, i.e. one job per 7 cycles.
- All outputs are registered or decoded from state only; there are no combinational paths from req or operands to outputs.
- Requests arriving while busy wait; the first IDLE cycle with req≠0 accepts.

## Test plan
- Reset, then req=01 with a=1, b=2, c=3, d=4, e=5 → grant=01 in S1; done=01 six cycles after acceptance; y1=30, y2=42.
- req=01 with all operands 15 (W=4) → y1=675, y2=1350, with no truncation.
- req=11 held from reset, each requester dropping req on its own grant → requester 0 served first, then requester 1. Then, with req=11 again, requester 0 wins (last=1).
- During a busy job, change op_*/req of the owner at S2 → results unchanged; the other request is accepted only after DONE→IDLE.
- Assert reset during S4 → outputs return to reset values immediately; no done pulse; the next job from req=10 completes normally.
- Back-to-back: keep req=01 high continuously → accepts spaced exactly 7 cycles apart; busy low for exactly one cycle between jobs.

Source files
------------

// File: rtl/fsmd_sched_if.sv
// Request/result bundle between the two requesters and the fsmd_sched scheduler.
// The master side drives requests and operands. The slave side returns the handshake and the results.
interface fsmd_sched_if #(
  parameter int W = 4
);
  localparam int RW = 2 * W + 3;

  logic [1:0]     req;
  logic [2*W-1:0] op_a;
  logic [2*W-1:0] op_b;
  logic [2*W-1:0] op_c;
  logic [2*W-1:0] op_d;
  logic [2*W-1:0] op_e;
  logic [1:0]     grant;
  logic [1:0]     done;
  logic [RW-1:0]  y1;
  logic [RW-1:0]  y2;
  logic           busy;
  logic [2:0]     state;

  modport master (
    output req, op_a, op_b, op_c, op_d, op_e,
    input  grant, done, y1, y2, busy, state
  );

  modport slave (
    input  req, op_a, op_b, op_c, op_d, op_e,
    output grant, done, y1, y2, busy, state
  );
endinterface

// File: rtl/fsmd_sched.sv
// Round-robin scheduler for two requesters that share one adder and one multiplier.
// For each accepted job it runs a six-step sequence that produces y1=(a+b+c)*e and y2=(a+b+c)*(c+d).
module fsmd_sched #(
  parameter int W = 4
) (
  input  logic          clk_i,
  input  logic          rst_i,
  fsmd_sched_if.slave   bus
);
  localparam int RW = 2 * W + 3;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    S1   = 3'd1,
    S2   = 3'd2,
    S3   = 3'd3,
    S4   = 3'd4,
    S5   = 3'd5,
    DONE = 3'd6
  } state_e;

  state_e        state_q, state_d;
  logic [RW-1:0] r1_q, r1_d, r2_q, r2_d, r3_q, r3_d;
  logic [RW-1:0] y1_q, y1_d, y2_q, y2_d;
  logic [W-1:0]  b_q, b_d, d_q, d_d, e_q, e_d;
  logic          owner_q, owner_d, last_q, last_d;

  logic          win;
  logic [W-1:0]  a_win, b_win, c_win, d_win, e_win;
  logic [RW-1:0] add_x, add_y, sum;
  logic [RW-1:0] mul_x, mul_y, prod;
  logic [1:0]    owner_onehot;

  function automatic logic [RW-1:0] zx(input logic [W-1:0] v);
    return {{(RW-W){1'b0}}, v};
  endfunction

  // On a tie, the requester that was not served last wins.
  always_comb begin
    win = 1'b0;
    case (bus.req)
      2'b10:   win = 1'b1;
      2'b11:   win = ~last_q;
      default: win = 1'b0;
    endcase
  end

  assign a_win = win ? bus.op_a[2*W-1:W] : bus.op_a[W-1:0];
  assign b_win = win ? bus.op_b[2*W-1:W] : bus.op_b[W-1:0];
  assign c_win = win ? bus.op_c[2*W-1:W] : bus.op_c[W-1:0];
  assign d_win = win ? bus.op_d[2*W-1:W] : bus.op_d[W-1:0];
  assign e_win = win ? bus.op_e[2*W-1:W] : bus.op_e[W-1:0];

  // A single adder and a single multiplier, with their operands steered by the current step.
  always_comb begin
    add_x = r1_q;
    add_y = r2_q;
    case (state_q)
      S2:      begin add_x = r2_q; add_y = r3_q; end
      S3:      begin add_x = r1_q; add_y = r3_q; end
      default: begin add_x = r1_q; add_y = r2_q; end
    endcase
    mul_x = r1_q;
    mul_y = (state_q == S5) ? r3_q : r2_q;
  end

  assign sum  = add_x + add_y;
  assign prod = mul_x * mul_y;

  always_comb begin
    state_d = state_q;
    r1_d    = r1_q;
    r2_d    = r2_q;
    r3_d    = r3_q;
    y1_d    = y1_q;
    y2_d    = y2_q;
    b_d     = b_q;
    d_d     = d_q;
    e_d     = e_q;
    owner_d = owner_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (|bus.req) begin
          state_d = S1;
          r1_d    = zx(a_win);
          r2_d    = zx(c_win);
          b_d     = b_win;
          d_d     = d_win;
          e_d     = e_win;
          owner_d = win;
          last_d  = win;
        end
      end
      S1: begin
        r1_d    = sum;
        r3_d    = zx(d_q);
        state_d = S2;
      end
      S2: begin
        r2_d    = sum;
        r3_d    = zx(b_q);
        state_d = S3;
      end
      S3: begin
        r1_d    = sum;
        state_d = S4;
      end
      S4: begin
        r2_d    = prod;
        r3_d    = zx(e_q);
        state_d = S5;
      end
      S5: begin
        r1_d    = prod;
        y1_d    = prod;
        y2_d    = r2_q;
        state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      r1_q    <= '0;
      r2_q    <= '0;
      r3_q    <= '0;
      y1_q    <= '0;
      y2_q    <= '0;
      b_q     <= '0;
      d_q     <= '0;
      e_q     <= '0;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      r1_q    <= r1_d;
      r2_q    <= r2_d;
      r3_q    <= r3_d;
      y1_q    <= y1_d;
      y2_q    <= y2_d;
      b_q     <= b_d;
      d_q     <= d_d;
      e_q     <= e_d;
      owner_q <= owner_d;
      last_q  <= last_d;
    end
  end

  assign owner_onehot = owner_q ? 2'b10 : 2'b01;
  assign bus.grant    = (state_q == S1)   ? owner_onehot : 2'b00;
  assign bus.done     = (state_q == DONE) ? owner_onehot : 2'b00;
  assign bus.busy     = (state_q != IDLE);
  assign bus.state    = state_q;
  assign bus.y1       = y1_q;
  assign bus.y2       = y2_q;
endmodule

// File: tb/tb_fsmd_sched.sv
// Directed and randomized jobs for fsmd_sched, checked against an arithmetic and arbitration reference model.
module tb_fsmd_sched;
  localparam int W = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fsmd_sched_if #(.W(W)) bus();
  fsmd_sched #(.W(W)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int last_acc = 0;
  int m_last;
  int prev_y1, prev_y2;
  logic [W-1:0] oa[2], ob[2], oc[2], od[2], oe[2];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic drive_ops();
    bus.op_a = {oa[1], oa[0]};
    bus.op_b = {ob[1], ob[0]};
    bus.op_c = {oc[1], oc[0]};
    bus.op_d = {od[1], od[0]};
    bus.op_e = {oe[1], oe[0]};
  endtask

  task automatic rand_ops();
    for (int i = 0; i < 2; i++) begin
      oa[i] = W'($urandom_range(0, 15));
      ob[i] = W'($urandom_range(0, 15));
      oc[i] = W'($urandom_range(0, 15));
      od[i] = W'($urandom_range(0, 15));
      oe[i] = W'($urandom_range(0, 15));
    end
    drive_ops();
  endtask

  function automatic int model_y1(input int i);
    return (int'(oa[i]) + int'(ob[i]) + int'(oc[i])) * int'(oe[i]);
  endfunction

  function automatic int model_y2(input int i);
    return (int'(oa[i]) + int'(ob[i]) + int'(oc[i])) * (int'(oc[i]) + int'(od[i]));
  endfunction

  // mode: 0 owner drops req on grant, 1 disturb inputs mid-job, 2 reset during S4,
  //       3 req held continuously, 4 req held and acceptance spacing checked
  task automatic do_job(input logic [1:0] rq, input int mode);
    int w, e1, e2;
    bus.req = rq;
    drive_ops();
    w  = (rq == 2'b01) ? 0 : (rq == 2'b10) ? 1 : 1 - m_last;
    e1 = model_y1(w);
    e2 = model_y2(w);
    @(posedge clk); #1;
    $display("job req=%b owner=%0d exp_y1=%0d exp_y2=%0d", rq, w, e1, e2);
    chk("grant_s1", bus.grant, 32'(1 << w));
    chk("state_s1", bus.state, 1);
    chk("busy_s1", bus.busy, 1);
    chk("done_s1", bus.done, 0);
    if (mode == 4) chk("accept_spacing", cyc - last_acc, 7);
    last_acc = cyc;
    m_last = w;
    if (mode < 3) bus.req[w] = 1'b0;
    for (int s = 2; s <= 5; s++) begin
      @(posedge clk); #1;
      chk("state_mid", bus.state, s);
      chk("grant_mid", bus.grant, 0);
      chk("done_mid", bus.done, 0);
      chk("y1_hold", bus.y1, prev_y1);
      chk("y2_hold", bus.y2, prev_y2);
      if (mode == 1 && s == 2) begin
        rand_ops();
        bus.req = 2'b11;
      end
      if (mode == 1 && s == 3) bus.req[w] = 1'b0;
      if (mode == 2 && s == 4) begin
        rst = 1'b1;
        #1;
        chk("rst_state", bus.state, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_grant", bus.grant, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_y1", bus.y1, 0);
        chk("rst_y2", bus.y2, 0);
        repeat (2) begin
          @(negedge clk);
          chk("rst_no_done", bus.done, 0);
        end
        rst = 1'b0;
        bus.req = 2'b00;
        m_last = 1;
        prev_y1 = 0;
        prev_y2 = 0;
        return;
      end
    end
    @(posedge clk); #1;
    chk("state_done", bus.state, 6);
    chk("done_pulse", bus.done, 32'(1 << w));
    chk("grant_done", bus.grant, 0);
    chk("y1", bus.y1, e1);
    chk("y2", bus.y2, e2);
    prev_y1 = e1;
    prev_y2 = e2;
    @(posedge clk); #1;
    chk("state_idle", bus.state, 0);
    chk("busy_idle", bus.busy, 0);
    chk("done_idle", bus.done, 0);
    chk("y1_idle", bus.y1, e1);
  endtask

  task automatic apply_reset(input logic [1:0] rq);
    rst = 1'b1;
    bus.req = rq;
    m_last = 1;
    prev_y1 = 0;
    prev_y2 = 0;
    repeat (2) @(negedge clk);
    chk("reset_state", bus.state, 0);
    chk("reset_grant", bus.grant, 0);
    chk("reset_done", bus.done, 0);
    chk("reset_y1", bus.y1, 0);
    chk("reset_y2", bus.y2, 0);
    chk("reset_busy", bus.busy, 0);
    rst = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      oa[i] = '0; ob[i] = '0; oc[i] = '0; od[i] = '0; oe[i] = '0;
    end
    drive_ops();
    apply_reset(2'b00);

    // Basic job and the all-ones width corner case
    oa[0] = 4'd1; ob[0] = 4'd2; oc[0] = 4'd3; od[0] = 4'd4; oe[0] = 4'd5;
    do_job(2'b01, 0);
    chk("y1_const", bus.y1, 30);
    chk("y2_const", bus.y2, 42);
    oa[0] = 4'd15; ob[0] = 4'd15; oc[0] = 4'd15; od[0] = 4'd15; oe[0] = 4'd15;
    do_job(2'b01, 0);
    chk("y1_max", bus.y1, 675);
    chk("y2_max", bus.y2, 1350);

    // Tie held from reset: 0 first, 1 back-to-back, then 0 wins the next tie
    rand_ops();
    apply_reset(2'b11);
    do_job(2'b11, 0);
    do_job(2'b10, 4);
    do_job(2'b11, 0);

    // Owner disturbs operands and requests mid-job; the other requester waits
    rand_ops();
    do_job(2'b01, 1);
    do_job(2'b10, 4);

    // Reset during S4, then a normal job from requester 1
    rand_ops();
    do_job(2'b01, 2);
    do_job(2'b10, 0);

    // Randomized jobs
    for (int k = 0; k < 10; k++) begin
      rand_ops();
      do_job(2'($urandom_range(1, 3)), 0);
    end

    // Continuous request from requester 0
    rand_ops();
    do_job(2'b01, 3);
    for (int k = 0; k < 3; k++) begin
      rand_ops();
      do_job(2'b01, 4);
    end
    bus.req = 2'b00;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
